// File: rtl/slave_receive_fifo_pkg.sv
// rtl/slave_receive_fifo_pkg.sv - byte width, occupancy sizing helper and UART states
package slave_receive_fifo_pkg;

    localparam int BYTE_W = 8;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 serial receiver, one-clk RxD_data_ready strobe per good frame
module uart_receiver
    import slave_receive_fifo_pkg::*;
#(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int baud_rate          = 115_200
) (
    input  logic              clk,
    input  logic              RxD,
    output logic              RxD_data_ready,
    output logic [BYTE_W-1:0] RxD_data
);
    localparam int          BIT_CYC   = comm_clk_frequency / baud_rate;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
    localparam logic [15:0] HALF_LAST = 16'(BIT_CYC / 2 - 1);

    logic [1:0]        sync_q;
    logic              rx;
    uart_state_t       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] sh_q, sh_d;

    assign rx       = sync_q[1];
    assign RxD_data = sh_q;

    always_ff @(posedge clk) begin
        sync_q  <= {sync_q[0], RxD};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        bit_q   <= bit_d;
        sh_q    <= sh_d;
    end

    // Samples land mid-bit: half a bit after the start edge, then whole bits.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        sh_d           = sh_q;
        RxD_data_ready = 1'b0;
        case (state_q)
            UART_IDLE: begin
                if (!rx) begin
                    state_d = UART_START;
                    cnt_d   = HALF_LAST;
                end
            end
            UART_START: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx) begin
                    state_d = UART_IDLE;
                end else begin
                    state_d = UART_DATA;
                    cnt_d   = BIT_LAST;
                    bit_d   = 3'd0;
                end
            end
            UART_DATA: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    sh_d  = {rx, sh_q[BYTE_W-1:1]};
                    cnt_d = BIT_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            UART_STOP: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d        = UART_IDLE;
                    RxD_data_ready = rx;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - first-word-fall-through FIFO with separate occupancy counter
module word_fifo
    import slave_receive_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    output logic                      full,
    input  logic                      pop,
    output logic                      empty,
    output logic [WIDTH-1:0]          head,
    output logic [level_w(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/slave_receive_fifo.sv
// rtl/slave_receive_fifo.sv - byte-to-word assembler with gap timeout feeding a word FIFO
module slave_receive_fifo
    import slave_receive_fifo_pkg::*;
#(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int WORD_BYTES         = 4,
    parameter bit MSB_FIRST          = 1'b1,
    parameter int FIFO_DEPTH         = 4,
    parameter int GAP_TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           RxD,
    output logic [BYTE_W*WORD_BYTES-1:0]   word_data,
    output logic                           word_valid,
    input  logic                           word_ready,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                           overflow,
    output logic                           gap_timeout
);
    localparam int              WW       = BYTE_W * WORD_BYTES;
    localparam int              CW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(WORD_BYTES - 1);
    localparam logic [31:0]     GAP_LAST = 32'(GAP_TIMEOUT_CYCLES - 1);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_strobe;
    logic [CW-1:0]     byte_cnt;
    logic [31:0]       gap_cnt;
    logic [WW-1:0]     asm_q;
    logic [WW-1:0]     full_word;
    logic              last_byte, push, fire;
    logic              fifo_full, fifo_empty;

    uart_receiver #(
        .comm_clk_frequency(comm_clk_frequency)
    ) u_rx (
        .clk           (clk),
        .RxD           (RxD),
        .RxD_data_ready(rx_strobe),
        .RxD_data      (rx_byte)
    );

    // The assembly register shifts so that a complete word pushes out every older byte.
    always_comb begin
        full_word = '0;
        if (MSB_FIRST) begin
            full_word = (asm_q << BYTE_W) | WW'(rx_byte);
        end else begin
            full_word = (asm_q >> BYTE_W) | (WW'(rx_byte) << (WW - BYTE_W));
        end
    end

    assign last_byte = (byte_cnt == LAST_IDX);
    assign push      = rx_strobe && last_byte;
    assign fire      = (GAP_TIMEOUT_CYCLES != 0) && (byte_cnt != '0) && !rx_strobe
                       && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            asm_q       <= '0;
            overflow    <= 1'b0;
            gap_timeout <= 1'b0;
        end else begin
            gap_timeout <= fire;
            if (push && fifo_full && !word_ready) begin
                overflow <= 1'b1;
            end
            if (rx_strobe) begin
                gap_cnt <= '0;
                if (last_byte) begin
                    byte_cnt <= '0;
                    asm_q    <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    asm_q    <= full_word;
                end
            end else if (fire) begin
                byte_cnt <= '0;
                gap_cnt  <= '0;
                asm_q    <= '0;
            end else if (byte_cnt != '0) begin
                gap_cnt <= gap_cnt + 32'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    word_fifo #(
        .WIDTH(WW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .push_data(full_word),
        .full     (fifo_full),
        .pop      (word_ready),
        .empty    (fifo_empty),
        .head     (word_data),
        .level    (fifo_level)
    );

    assign word_valid = !fifo_empty;

endmodule
